// File: rtl/bus_latches.sv
// bus_latches: cpu6502 bus receive side, latching DB/SB/ADL/ADH into architectural and interface registers.
module bus_latches #(
  parameter logic [7:0]  RESET_S  = 8'hFD,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_bus_db,
  input  logic [7:0]  i_bus_sb,
  input  logic [7:0]  i_bus_adl,
  input  logic [7:0]  i_bus_adh,
  input  logic [7:0]  i_data,
  input  logic        i_sb_x,
  input  logic        i_sb_y,
  input  logic        i_sb_ac,
  input  logic        i_sb_s,
  input  logic        i_adl_pcl,
  input  logic        i_adh_pch,
  input  logic        i_i_pc,
  input  logic        i_adl_abl,
  input  logic        i_adh_abh,
  input  logic        i_db_dor,
  input  logic        i_dl_load,
  output logic [7:0]  o_x,
  output logic [7:0]  o_y,
  output logic [7:0]  o_ac,
  output logic [7:0]  o_s,
  output logic [7:0]  o_pcl,
  output logic [7:0]  o_pch,
  output logic [7:0]  o_dl,
  output logic [7:0]  o_dor,
  output logic [15:0] o_address
);
  logic [7:0]  abl, abh;
  logic [15:0] pc_next;
  // Source mux first, then a full 16-bit increment so the PCL carry lands in PCH the same cycle.
  always_comb pc_next = {i_adh_pch ? i_bus_adh : o_pch, i_adl_pcl ? i_bus_adl : o_pcl} + 16'(i_i_pc);
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_x   <= '0;
      o_y   <= '0;
      o_ac  <= '0;
      o_s   <= RESET_S;
      {o_pch, o_pcl} <= RESET_PC;
      abl   <= '0;
      abh   <= '0;
      o_dor <= '0;
      o_dl  <= '0;
    end else begin
      if (i_sb_x)    o_x   <= i_bus_sb;
      if (i_sb_y)    o_y   <= i_bus_sb;
      if (i_sb_ac)   o_ac  <= i_bus_sb;
      if (i_sb_s)    o_s   <= i_bus_sb;
      {o_pch, o_pcl} <= pc_next;
      if (i_adl_abl) abl   <= i_bus_adl;
      if (i_adh_abh) abh   <= i_bus_adh;
      if (i_db_dor)  o_dor <= i_bus_db;
      if (i_dl_load) o_dl  <= i_data;
    end
  end
  assign o_address = {abh, abl};
endmodule
